cdb_bus: RTL and testbench

CDB_BUS -- requirements
Module: cdb_bus

---
 rtl/cdb_bus_if.sv | 25 ++
 rtl/cdb_bus.sv | 111 +++++++++++
 tb/tb_cdb_bus.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_bus_if.sv
// cdb_bus_if: ALU/LSB result handshakes and the common data bus broadcast
interface cdb_bus_if;
    logic        alu_valid;
    logic [31:0] alu_addr;
    logic [31:0] alu_val;
    logic        alu_ready;
    logic        lsb_valid;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_val;
    logic        lsb_ready;
    logic        cdb_active;
    logic [31:0] cdb_addr;
    logic [31:0] cdb_val;
    logic        cdb_src;

    modport master (
        output alu_valid, alu_addr, alu_val, lsb_valid, lsb_addr, lsb_val,
        input  alu_ready, lsb_ready, cdb_active, cdb_addr, cdb_val, cdb_src
    );

    modport slave (
        input  alu_valid, alu_addr, alu_val, lsb_valid, lsb_addr, lsb_val,
        output alu_ready, lsb_ready, cdb_active, cdb_addr, cdb_val, cdb_src
    );
endinterface

// File: rtl/cdb_bus.sv
// cdb_bus: per-source result FIFOs arbitrated round-robin onto one registered broadcast bus
module cdb_bus #(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     flush,
    cdb_bus_if.slave bus
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(QUEUE_DEPTH);

    // index 0 is the ALU queue, index 1 the LSB queue; entries are {addr, val}
    logic [63:0]   mem_q   [2][QUEUE_DEPTH];
    logic [63:0]   mem_d   [2][QUEUE_DEPTH];
    logic [AW-1:0] front_q [2];
    logic [AW-1:0] front_d [2];
    logic [AW-1:0] rear_q  [2];
    logic [AW-1:0] rear_d  [2];
    logic [AW:0]   count_q [2];
    logic [AW:0]   count_d [2];
    logic          last_q, last_d;
    logic          active_q, active_d;
    logic          src_q, src_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   val_q, val_d;
    logic [63:0]   din [2];
    logic [1:0]    valid, ready, busy, push, pop;
    logic          grant, any;

    assign din[0] = {bus.alu_addr, bus.alu_val};
    assign din[1] = {bus.lsb_addr, bus.lsb_val};
    assign valid  = {bus.lsb_valid, bus.alu_valid};
    // a full queue refuses even when it is popped the same edge
    assign ready[0] = rdy_in && !flush && count_q[0] != FULL;
    assign ready[1] = rdy_in && !flush && count_q[1] != FULL;
    assign busy     = {count_q[1] != '0, count_q[0] != '0};
    assign any      = |busy;
    // on contention the source not granted last wins
    assign grant    = &busy ? !last_q : busy[1];
    assign push     = valid & ready;
    assign pop      = {any && grant, any && !grant};

    assign bus.alu_ready  = ready[0];
    assign bus.lsb_ready  = ready[1];
    assign bus.cdb_active = active_q;
    assign bus.cdb_addr   = addr_q;
    assign bus.cdb_val    = val_q;
    assign bus.cdb_src    = src_q;

    // next state: pushes, one arbitrated pop into the output registers, flush and pause
    always_comb begin
        mem_d    = mem_q;
        front_d  = front_q;
        rear_d   = rear_q;
        count_d  = count_q;
        last_d   = last_q;
        active_d = active_q;
        src_d    = src_q;
        addr_d   = addr_q;
        val_d    = val_q;
        if (rdy_in && flush) begin
            front_d  = '{default: '0};
            rear_d   = '{default: '0};
            count_d  = '{default: '0};
            active_d = 1'b0;
            src_d    = 1'b0;
            addr_d   = '0;
            val_d    = '0;
        end else if (rdy_in) begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    mem_d[s][rear_q[s]] = din[s];
                    rear_d[s] = rear_q[s] + AW'(1);
                end
                if (pop[s]) front_d[s] = front_q[s] + AW'(1);
                count_d[s] = count_q[s] + (AW+1)'(push[s]) - (AW+1)'(pop[s]);
            end
            active_d        = any;
            src_d           = any && grant;
            {addr_d, val_d} = any ? mem_q[grant][front_q[grant]] : 64'd0;
            last_d          = any ? grant : last_q;
        end
    end

    // state registers; reset clears everything and hands the first contention to the ALU
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_q    <= '{default: '0};
            front_q  <= '{default: '0};
            rear_q   <= '{default: '0};
            count_q  <= '{default: '0};
            last_q   <= 1'b1;
            active_q <= 1'b0;
            src_q    <= 1'b0;
            addr_q   <= '0;
            val_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            front_q  <= front_d;
            rear_q   <= rear_d;
            count_q  <= count_d;
            last_q   <= last_d;
            active_q <= active_d;
            src_q    <= src_d;
            addr_q   <= addr_d;
            val_q    <= val_d;
        end
    end
endmodule

// File: tb/tb_cdb_bus.sv
// tb_cdb_bus: scenario tasks feeding a per-source scoreboard checked on every broadcast
module tb_cdb_bus;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    logic flush  = 1'b0;
    logic fresh  = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    logic [63:0] exp_alu[$];
    logic [63:0] exp_lsb[$];

    cdb_bus_if bus();

    cdb_bus #(.QUEUE_DEPTH(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .flush  (flush),
        .bus    (bus)
    );

    // free-running clock
    always #5 clk_in = ~clk_in;

    // a new broadcast can only appear after an enabled, non-reset edge
    always @(posedge clk_in) fresh <= rdy_in && rst_in;

    // scoreboard consumer: every fresh broadcast must match its source's oldest pending entry
    always @(negedge clk_in) begin
        logic [63:0] e;
        if (fresh && bus.cdb_active) begin
            n_cmp++;
            if (bus.cdb_src ? exp_lsb.size() == 0 : exp_alu.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got src=%0d addr=%h val=%h, required no broadcast", bus.cdb_src, bus.cdb_addr, bus.cdb_val);
            end else begin
                if (bus.cdb_src) e = exp_lsb.pop_front();
                else e = exp_alu.pop_front();
                if ({bus.cdb_addr, bus.cdb_val} !== e) begin
                    n_bad++;
                    $display("FAIL sb_order: src=%0d got %h required %h", bus.cdb_src, {bus.cdb_addr, bus.cdb_val}, e);
                end
            end
        end
    end

    // hard stop if something never returns
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic av, input logic [31:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [31:0] la, input logic [31:0] ld);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_val   = ad;
        bus.lsb_valid = lv;
        bus.lsb_addr  = la;
        bus.lsb_val   = ld;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_in = 1'b0;
        exp_alu.delete();
        exp_lsb.delete();
        #2;
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_in = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({bus.cdb_active, bus.cdb_src, bus.cdb_addr, bus.cdb_val} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0", {bus.cdb_active, bus.cdb_src, bus.cdb_addr, bus.cdb_val});
        end
        rst_in = 1'b1;
        #1;
        n_cmp++;
        if ({bus.alu_ready, bus.lsb_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_ready: got %b required 11", {bus.alu_ready, bus.lsb_ready});
        end
        tick();
        n_cmp++;
        if (bus.cdb_active !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got active=%b required 0", bus.cdb_active);
        end
    endtask

    task automatic test_single();
        drive(1, 32'h1000, 32'h1, 0, 0, 0);
        exp_alu.push_back({32'h1000, 32'h1});
        #1;
        n_cmp++;
        if (bus.alu_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL single_ready: got %b required 1", bus.alu_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (bus.cdb_active !== 1'b0) begin
            n_bad++;
            $display("FAIL single_latency: got active=%b right after push required 0", bus.cdb_active);
        end
        tick();
        n_cmp++;
        if ({bus.cdb_active, bus.cdb_src, bus.cdb_addr, bus.cdb_val} !== {1'b1, 1'b0, 32'h1000, 32'h1}) begin
            n_bad++;
            $display("FAIL single_bcast: got %b/%b/%h/%h required 1/0/00001000/00000001", bus.cdb_active, bus.cdb_src, bus.cdb_addr, bus.cdb_val);
        end
        tick();
        n_cmp++;
        if (bus.cdb_active !== 1'b0) begin
            n_bad++;
            $display("FAIL single_after: got active=%b required 0", bus.cdb_active);
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            if (k <= 6) begin
                drive(1, 32'h2000 + k, k, 1, 32'h3000 + k, 32'h100 + k);
                exp_alu.push_back({32'h2000 + k, 32'(k)});
                exp_lsb.push_back({32'h3000 + k, 32'h100 + k});
            end else drive(0, 0, 0, 0, 0, 0);
            tick();
            if (k >= 2) begin
                n_cmp++;
                if ({bus.cdb_active, bus.cdb_src} !== {1'b1, 1'(k % 2)}) begin
                    n_bad++;
                    $display("FAIL contention_rr edge %0d: got active=%b src=%b required 1/%0d", k, bus.cdb_active, bus.cdb_src, k % 2);
                end
            end
        end
        tick();
        n_cmp++;
        if (bus.cdb_active !== 1'b0 || exp_alu.size() + exp_lsb.size() != 0) begin
            n_bad++;
            $display("FAIL contention_drain: got active=%b pending=%0d required 0/0", bus.cdb_active, exp_alu.size() + exp_lsb.size());
        end
    endtask

    task automatic test_full();
        logic al, ll;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            al = (k <= 7) || (k % 2 == 1);
            ll = (k <= 6) || (k % 2 == 0);
            drive(1, 32'h4000 + k, 32'hA0 + k, 1, 32'h5000 + k, 32'hB0 + k);
            #1;
            n_cmp++;
            if ({bus.alu_ready, bus.lsb_ready} !== {al, ll}) begin
                n_bad++;
                $display("FAIL full_ready cycle %0d: got %b required %b", k, {bus.alu_ready, bus.lsb_ready}, {al, ll});
            end
            if (al) exp_alu.push_back({32'h4000 + k, 32'hA0 + k});
            if (ll) exp_lsb.push_back({32'h5000 + k, 32'hB0 + k});
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && exp_alu.size() + exp_lsb.size() != 0; i++) tick();
        tick();
        n_cmp++;
        if (bus.cdb_active !== 1'b0 || exp_alu.size() + exp_lsb.size() != 0) begin
            n_bad++;
            $display("FAIL full_drain: got active=%b pending=%0d required 0/0", bus.cdb_active, exp_alu.size() + exp_lsb.size());
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 32'h6001, 32'h11, 1, 32'h7001, 32'h21);
        exp_alu.push_back({32'h6001, 32'h11});
        exp_lsb.push_back({32'h7001, 32'h21});
        tick();
        drive(1, 32'h6002, 32'h12, 1, 32'h7002, 32'h22);
        exp_alu.push_back({32'h6002, 32'h12});
        exp_lsb.push_back({32'h7002, 32'h22});
        tick();
        drive(1, 32'h6003, 32'h13, 1, 32'h7003, 32'h23);
        flush = 1'b1;
        #1;
        n_cmp++;
        if ({bus.alu_ready, bus.lsb_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL flush_ready: got %b required 00", {bus.alu_ready, bus.lsb_ready});
        end
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        exp_alu.delete();
        exp_lsb.delete();
        n_cmp++;
        if ({bus.cdb_active, bus.cdb_src, bus.cdb_addr, bus.cdb_val} !== 66'd0) begin
            n_bad++;
            $display("FAIL flush_outputs: got %h required 0", {bus.cdb_active, bus.cdb_src, bus.cdb_addr, bus.cdb_val});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (bus.cdb_active !== 1'b0) begin
                n_bad++;
                $display("FAIL flush_idle %0d: got active=%b required 0", i, bus.cdb_active);
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        drive(1, 32'h8001, 32'h31, 1, 32'h9001, 32'h41);
        exp_alu.push_back({32'h8001, 32'h31});
        exp_lsb.push_back({32'h9001, 32'h41});
        tick();
        drive(1, 32'h8002, 32'h32, 1, 32'h9002, 32'h42);
        exp_alu.push_back({32'h8002, 32'h32});
        exp_lsb.push_back({32'h9002, 32'h42});
        tick();
        rdy_in = 1'b0;
        drive(1, 32'h8003, 32'h33, 1, 32'h9003, 32'h43);
        #1;
        n_cmp++;
        if ({bus.alu_ready, bus.lsb_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL pause_ready: got %b required 00", {bus.alu_ready, bus.lsb_ready});
        end
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            tick();
            n_cmp++;
            if ({bus.cdb_active, bus.cdb_src, bus.cdb_addr, bus.cdb_val} !== {1'b1, 1'b0, 32'h8001, 32'h31}) begin
                n_bad++;
                $display("FAIL pause_hold %0d: got %b/%b/%h/%h required 1/0/00008001/00000031", i, bus.cdb_active, bus.cdb_src, bus.cdb_addr, bus.cdb_val);
            end
        end
        flush = 1'b0;
        rdy_in = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        n_cmp++;
        if ({bus.cdb_active, bus.cdb_src, bus.cdb_addr} !== {1'b1, 1'b1, 32'h9001}) begin
            n_bad++;
            $display("FAIL pause_resume: got %b/%b/%h required 1/1/00009001", bus.cdb_active, bus.cdb_src, bus.cdb_addr);
        end
        for (int i = 0; i < 10 && exp_alu.size() + exp_lsb.size() != 0; i++) tick();
        tick();
        n_cmp++;
        if (bus.cdb_active !== 1'b0 || exp_alu.size() + exp_lsb.size() != 0) begin
            n_bad++;
            $display("FAIL pause_drain: got active=%b pending=%0d required 0/0", bus.cdb_active, exp_alu.size() + exp_lsb.size());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, 32'hC001, 32'h51, 1, 32'hD001, 32'h61);
        exp_alu.push_back({32'hC001, 32'h51});
        exp_lsb.push_back({32'hD001, 32'h61});
        tick();
        drive(1, 32'hC002, 32'h52, 1, 32'hD002, 32'h62);
        exp_alu.push_back({32'hC002, 32'h52});
        exp_lsb.push_back({32'hD002, 32'h62});
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst_in = 1'b0;
        #1;
        n_cmp++;
        if ({bus.cdb_active, bus.cdb_src, bus.cdb_addr, bus.cdb_val} !== 66'd0) begin
            n_bad++;
            $display("FAIL async_reset_outputs: got %h required 0", {bus.cdb_active, bus.cdb_src, bus.cdb_addr, bus.cdb_val});
        end
        exp_alu.delete();
        exp_lsb.delete();
        tick();
        rst_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (bus.cdb_active !== 1'b0 || {bus.alu_ready, bus.lsb_ready} !== 2'b11) begin
                n_bad++;
                $display("FAIL async_reset_idle %0d: got active=%b ready=%b required 0/11", i, bus.cdb_active, {bus.alu_ready, bus.lsb_ready});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_flush();
        test_pause();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
